// File: rtl/vid_bank_writer_if.sv
// Request/SRAM-side bundle for vid_bank_writer: the master drives append requests,
// the writer drives the per-bank SRAM strobes and status.
interface vid_bank_writer_if #(
  parameter int K       = 16,
  parameter int Q       = 16,
  parameter int VID_BW  = 16,
  parameter int ADDR_BW = 4
);
  logic                     enable;
  logic [K-1:0]             in_wen;
  logic [K*Q*VID_BW-1:0]    in_wdata;
  logic                     in_finish;
  logic [K-1:0]             sram_csb;
  logic [K-1:0]             sram_wsb;
  logic [K*ADDR_BW-1:0]     sram_waddr;
  logic [K*Q*VID_BW-1:0]    sram_wdata;
  logic [K-1:0]             bank_full;
  logic                     overflow;
  logic [ADDR_BW+7:0]       rows_written;
  logic                     done;

  modport master (
    output enable, in_wen, in_wdata, in_finish,
    input  sram_csb, sram_wsb, sram_waddr, sram_wdata,
    input  bank_full, overflow, rows_written, done
  );

  modport slave (
    input  enable, in_wen, in_wdata, in_finish,
    output sram_csb, sram_wsb, sram_waddr, sram_wdata,
    output bank_full, overflow, rows_written, done
  );
endinterface

// File: rtl/vid_bank_writer.sv
// Appends vertex-ID rows into K single-port SRAM banks, one write pointer per bank.
// Optional macro ZERO_FILL_EN: DRAIN pads every bank with all-ones rows until full.
module vid_bank_writer #(
  parameter int K       = 16,
  parameter int Q       = 16,
  parameter int VID_BW  = 16,
  parameter int ADDR_BW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  vid_bank_writer_if.slave   bus
);
  localparam int ROW_W = Q * VID_BW;
  localparam int CNT_W = ADDR_BW + 8;
  localparam logic [ADDR_BW:0] FULL_PTR = (ADDR_BW+1)'(2**ADDR_BW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Array element i is bit position i of the packed buses, i.e. bank K-1-i.
  state_t                    state_q;
  logic [K-1:0][ADDR_BW:0]   ptr_q, ptr_d;
  logic [K-1:0]              csb_q, wsb_q, wr_d;
  logic [K-1:0][ADDR_BW-1:0] waddr_q, waddr_d;
  logic [K-1:0][ROW_W-1:0]   wdata_q, wdata_d;
  logic [K-1:0][ROW_W-1:0]   in_rows;
  logic [K-1:0]              full;
  logic                      ovf_q, ovf_d;
  logic [CNT_W-1:0]          rows_q, rows_d, n_acc;
  logic                      done_q;
  logic                      run_go;
  logic                      drain_end;

  assign in_rows = bus.in_wdata;
  assign run_go  = (state_q == RUN) && bus.enable;

  always_comb begin
    for (int i = 0; i < K; i++) full[i] = (ptr_q[i] == FULL_PTR);
  end

`ifdef ZERO_FILL_EN
  assign drain_end = &full;
`else
  assign drain_end = 1'b1;
`endif

  always_comb begin
    wr_d    = '0;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    n_acc   = '0;
    for (int i = 0; i < K; i++) begin
      if (run_go && bus.in_wen[i]) begin
        if (!full[i]) begin
          wr_d[i]    = 1'b1;
          waddr_d[i] = ptr_q[i][ADDR_BW-1:0];
          wdata_d[i] = in_rows[i];
          ptr_d[i]   = ptr_q[i] + (ADDR_BW+1)'(1);
          n_acc      = n_acc + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
`ifdef ZERO_FILL_EN
      else if (state_q == DRAIN && !full[i]) begin
        wr_d[i]    = 1'b1;
        waddr_d[i] = ptr_q[i][ADDR_BW-1:0];
        wdata_d[i] = '1;
        ptr_d[i]   = ptr_q[i] + (ADDR_BW+1)'(1);
        n_acc      = n_acc + CNT_W'(1);
      end
`endif
    end
    rows_d = rows_q + n_acc;
  end

  // Stage boundary: accepted requests become SRAM strobes one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      csb_q   <= '1;
      wsb_q   <= '1;
      waddr_q <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      rows_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      csb_q   <= ~wr_d;
      wsb_q   <= ~wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
      rows_q  <= rows_d;
      case (state_q)
        IDLE:    if (bus.enable) state_q <= RUN;
        RUN:     if (bus.enable && bus.in_finish) state_q <= DRAIN;
        DRAIN:   if (drain_end) begin
                   state_q <= DONE;
                   done_q  <= 1'b1;
                 end
        default: state_q <= DONE;
      endcase
    end
  end

  assign bus.sram_csb     = csb_q;
  assign bus.sram_wsb     = wsb_q;
  assign bus.sram_waddr   = waddr_q;
  assign bus.sram_wdata   = wdata_q;
  assign bus.bank_full    = full;
  assign bus.overflow     = ovf_q;
  assign bus.rows_written = rows_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_vid_bank_writer.sv
// Bench for vid_bank_writer: directed and random append traffic against a per-bank
// fill-count reference model.
module tb_vid_bank_writer;
  localparam int K       = 16;
  localparam int Q       = 16;
  localparam int VID_BW  = 16;
  localparam int ADDR_BW = 4;
  localparam int ROW_W   = Q * VID_BW;
  localparam int DEPTH   = 2**ADDR_BW;
  localparam int CNT_W   = ADDR_BW + 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vid_bank_writer_if #(.K(K), .Q(Q), .VID_BW(VID_BW), .ADDR_BW(ADDR_BW)) bus ();

  vid_bank_writer #(.K(K), .Q(Q), .VID_BW(VID_BW), .ADDR_BW(ADDR_BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, indexed by bank number b.
  int                 fill [K];
  int                 total;
  bit                 ovf;
  int                 phase;       // 0 idle, 1 run, 2 drain, 3 done
  logic [K-1:0]       exp_wr;      // packed bit order, bank b at bit K-1-b
  logic [ADDR_BW-1:0] last_addr [K];
  logic [ROW_W-1:0]   last_data [K];

  function automatic void accept(input int b, input logic [ROW_W-1:0] row);
    exp_wr[K-1-b] = 1'b1;
    last_addr[b]  = ADDR_BW'(fill[b]);
    last_data[b]  = row;
    fill[b]++;
    total++;
  endfunction

  function automatic void model(input bit rstn, input bit en, input logic [K-1:0] wen,
                                input bit fin, input logic [K*ROW_W-1:0] d);
    bit allf;
    exp_wr = '0;
    if (!rstn) begin
      for (int b = 0; b < K; b++) begin
        fill[b] = 0; last_addr[b] = '0; last_data[b] = '0;
      end
      total = 0; ovf = 1'b0; phase = 0;
      return;
    end
    allf = 1'b1;
    for (int b = 0; b < K; b++) if (fill[b] != DEPTH) allf = 1'b0;
    if (phase == 1 && en) begin
      for (int b = 0; b < K; b++)
        if (wen[K-1-b]) begin
          if (fill[b] < DEPTH) accept(b, d[(K-b)*ROW_W-1 -: ROW_W]);
          else ovf = 1'b1;
        end
    end
`ifdef ZERO_FILL_EN
    if (phase == 2)
      for (int b = 0; b < K; b++) if (fill[b] < DEPTH) accept(b, '1);
`endif
    case (phase)
      0: if (en) phase = 1;
      1: if (en && fin) phase = 2;
`ifdef ZERO_FILL_EN
      2: if (allf) phase = 3;
`else
      2: phase = 3;
`endif
      default: phase = 3;
    endcase
  endfunction

  task automatic check_outputs();
    logic [K*ADDR_BW-1:0] ea;
    logic [K-1:0]         ef;
    ea = '0;
    ef = '0;
    for (int b = 0; b < K; b++) begin
      ea[(K-b)*ADDR_BW-1 -: ADDR_BW] = last_addr[b];
      ef[K-1-b] = (fill[b] == DEPTH);
    end
    checks++;
    assert (bus.sram_csb === ~exp_wr) else begin
      errors++; $error("FAIL csb got %h exp %h", bus.sram_csb, ~exp_wr);
    end
    checks++;
    assert (bus.sram_wsb === ~exp_wr) else begin
      errors++; $error("FAIL wsb got %h exp %h", bus.sram_wsb, ~exp_wr);
    end
    checks++;
    assert (bus.sram_waddr === ea) else begin
      errors++; $error("FAIL waddr got %h exp %h", bus.sram_waddr, ea);
    end
    for (int b = 0; b < K; b++) begin
      checks++;
      assert (bus.sram_wdata[(K-b)*ROW_W-1 -: ROW_W] === last_data[b]) else begin
        errors++;
        $error("FAIL wdata bank %0d got %h exp %h", b,
               bus.sram_wdata[(K-b)*ROW_W-1 -: ROW_W], last_data[b]);
      end
    end
    checks++;
    assert (bus.bank_full === ef) else begin
      errors++; $error("FAIL bank_full got %h exp %h", bus.bank_full, ef);
    end
    checks++;
    assert (bus.overflow === ovf) else begin
      errors++; $error("FAIL overflow got %b exp %b", bus.overflow, ovf);
    end
    checks++;
    assert (bus.rows_written === CNT_W'(total)) else begin
      errors++; $error("FAIL rows_written got %0d exp %0d", bus.rows_written, total);
    end
    checks++;
    assert (bus.done === (phase == 3)) else begin
      errors++; $error("FAIL done got %b exp %b", bus.done, (phase == 3));
    end
  endtask

  task automatic step(input bit rstn, input bit en, input logic [K-1:0] wen, input bit fin);
    logic [K*ROW_W-1:0] d;
    for (int j = 0; j < K*ROW_W/32; j++) d[j*32 +: 32] = $urandom();
    @(negedge clk);
    rst_n         = rstn;
    bus.enable    = en;
    bus.in_wen    = wen;
    bus.in_finish = fin;
    bus.in_wdata  = d;
    model(rstn, en, wen, fin, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.in_wen    = '0;
    bus.in_finish = 1'b0;
    bus.in_wdata  = '0;
    total = 0; ovf = 1'b0; phase = 0; exp_wr = '0;

    step(0, 0, '0, 0);
    step(0, 1, 16'hFFFF, 0);
    // IDLE -> RUN, request in the same cycle is not taken
    step(1, 1, 16'hFFFF, 0);
    for (int n = 0; n < 3; n++) step(1, 1, 16'h8000, 0);
    step(1, 0, 16'hFFFF, 0);
    step(1, 0, 16'hFFFF, 1);
    step(1, 1, 16'hFFFF, 0);
    for (int n = 0; n < 40; n++)
      step(1, ($urandom_range(0, 3) != 0), K'($urandom() & $urandom()), 1'b0);
    for (int n = 0; n < 18; n++) step(1, 1, 16'hFFFF, 0);
    step(1, 1, 16'h0F0F, 0);
    // mid-run reset
    step(1, 1, 16'h00FF, 0);
    step(0, 1, 16'hFFFF, 0);
    step(0, 1, 16'hFFFF, 0);
    step(1, 1, 16'h0000, 0);
    step(1, 1, 16'h4002, 0);
    step(1, 1, 16'h0001, 1);
    for (int n = 0; n < 20; n++) step(1, 1, 16'hFFFF, (n % 2 == 0));
    step(1, 0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vid_bank_writer.md
Name: vid_bank_writer

Overview:
Downstream of master_top. Consumes the per-epoch vertex-ID write requests (vidsram_wen, vidsram_wdata) and commits them to K single-port vertex-ID SRAM banks. Each bank has its own write pointer, so master only says "append this row to bank b". Tracks fill level and overflow, and signals completion once master finishes and the last write has been issued.

Parameters:
K, 16, number of banks (partitions)
Q, 16, vertex IDs per row
VID_BW, 16, bits per vertex ID
ADDR_BW, 4, bank address width; depth DEPTH = 2**ADDR_BW rows per bank

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  block enable; when 0, incoming requests are ignored and state holds
in_wen  in  K  per-bank append request from master; bit K-1-b selects bank b (MSB = bank 0), 1 = write
in_wdata  in  K*Q*VID_BW  row data; bank b occupies bits [(K-b)*Q*VID_BW-1 -: Q*VID_BW]
in_finish  in  1  master finish; level, sampled each cycle
sram_csb  out  K  per-bank chip select, active low, same bit order as in_wen
sram_wsb  out  K  per-bank write strobe, active low
sram_waddr  out  K*ADDR_BW  per-bank address; bank b at [(K-b)*ADDR_BW-1 -: ADDR_BW]
sram_wdata  out  K*Q*VID_BW  per-bank write data, same packing as in_wdata
bank_full  out  K  bank has DEPTH rows committed
overflow  out  1  sticky; a request hit a full bank
rows_written  out  ADDR_BW+8  total rows committed, all banks
done  out  1  all writes issued after in_finish

Behaviour:
- All state changes on posedge clk. While rst_n=0: state=IDLE; all pointers 0; sram_csb, sram_wsb all 1s; sram_waddr=0; sram_wdata=0; bank_full=0; overflow=0; rows_written=0; done=0. Reset mid-operation drops all in-flight requests; the next run restarts at address 0 in every bank.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when enable=1. RUN -> DRAIN on the first cycle with in_finish=1 and enable=1. DRAIN -> DONE after 1 cycle; this flushes the output register stage. DONE is held until reset; done=1 only in DONE.
- In RUN, per bank b, each cycle with enable=1 and request bit set:
  - If ptr[b] < DEPTH, register a write. Next cycle: csb[b]=0, wsb[b]=0, waddr[b]=ptr[b], wdata[b]=row. Then ptr[b]++ and rows_written++.
  - If the bank is full, drop the write (csb and wsb stay 1) and set overflow=1.
- Latency is exactly 1 cycle from in_wen to the SRAM strobe. Any number of banks may write in the same cycle. rows_written adds the popcount of accepted writes per cycle.
- Unselected banks: csb=1, wsb=1. waddr and wdata hold their last value.
- ptr[b] is ADDR_BW+1 bits. bank_full[b] = (ptr[b]==DEPTH). There is no wrap-around: a full bank never rewrites address 0.
- Requests arriving in the same cycle as in_finish are accepted. Requests in DRAIN or DONE are ignored and do not set overflow.
- enable=0 in RUN: no new writes, FSM holds, and a write already registered still issues next cycle.

Optional Feature:
ZERO_FILL_EN
- Defined: DRAIN lasts until every bank is full. Each cycle, every non-full bank writes a sentinel row (all IDs = {VID_BW{1'b1}}) at ptr[b] and increments ptr[b]. Banks fill in parallel, so DRAIN lasts DEPTH - min(ptr) + 1 cycles. rows_written counts sentinel rows. DONE implies bank_full = all 1s.
- Undefined: DRAIN is 1 cycle, and unwritten SRAM rows are left untouched.

Test Plan:
1. Reset with rst_n=0 for 2 cycles mid-RUN -> next cycle all csb/wsb=16'hFFFF, rows_written=0, overflow=0, done=0.
2. in_wen=16'h8000, bank 0 data=256'h0001..000F, for 3 cycles -> bank 0 strobes at waddr 0,1,2, each 1 cycle after its request; other banks csb=1; rows_written=3.
3. in_wen=16'hFFFF for 16 cycles -> all banks write addr 0..15; bank_full=16'hFFFF; rows_written=256; a 17th request sets overflow=1 with no strobes.
4. in_wen=16'h0001 and in_finish=1 in the same cycle -> bank 15 writes addr 0; done=1 two cycles later; later in_wen=16'hFFFF is ignored.
5. enable=0 for 2 cycles with in_wen=16'hFFFF -> no strobes and pointers unchanged; enable=1 resumes at the previous addresses.
6. ZERO_FILL_EN defined, bank 3 holds 5 rows and all other banks are full, then in_finish -> bank 3 writes FFFF rows at addr 5..15 over 11 cycles; done=1 when bank_full=16'hFFFF.
